// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_OP,
    RD_A1,
    RD_A2,
    PRESENT,
    HALT
  } fetch_state_e;

  localparam logic [7:0] OP_HALT     = 8'h00;
  localparam int         FETCH_BYTES = 3;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads opcode + two argument bytes from a
// latency-1 byte memory, presents them to control and advances on op_done.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDRW = 16,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_en,
  input  logic [7:0]       mem_data,
  output logic [7:0]       op_code,
  output logic [7:0]       arg1,
  output logic [7:0]       arg2,
  input  logic [15:0]      offset,
  input  logic             op_done,
  output logic [ADDRW-1:0] pc,
  output logic             busy,
  output logic             halted,
  output logic [CNTW-1:0]  retired
);

  // Offset is sign-extended to at least the PC width before the add.
  localparam int EW = (ADDRW > 16) ? ADDRW : 16;

  fetch_state_e     state, state_nxt;
  logic [ADDRW-1:0] pc_q;
  logic [7:0]       ir, arg1_q, arg2_q;
  logic [CNTW-1:0]  retired_q;
  logic             present_first;
  logic [EW-1:0]    off_ext;
  logic             advance;

  assign off_ext = EW'($signed(offset));
  assign advance = (state == PRESENT) && op_done && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RD_OP;
    end else begin
      case (state)
        RD_OP:   state_nxt = RD_A1;
        RD_A1:   state_nxt = RD_A2;
        RD_A2:   state_nxt = (ir == OP_HALT) ? HALT : PRESENT;
        PRESENT: if (op_done) state_nxt = RD_OP;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_addr = pc_q;
    busy     = 1'b0;
    halted   = 1'b0;
    op_code  = OP_HALT;
    case (state)
      RD_OP: begin
        mem_en = 1'b1;
        busy   = 1'b1;
      end
      RD_A1: begin
        mem_en   = 1'b1;
        mem_addr = pc_q + ADDRW'(1);
        busy     = 1'b1;
      end
      RD_A2: begin
        mem_en   = 1'b1;
        mem_addr = pc_q + ADDRW'(FETCH_BYTES - 1);
        busy     = 1'b1;
      end
      PRESENT: begin
        busy = 1'b1;
        // Masked once op_done is seen so control never re-executes it.
        if (!op_done) op_code = ir;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= '0;
      ir            <= '0;
      arg1_q        <= '0;
      arg2_q        <= '0;
      retired_q     <= '0;
      present_first <= 1'b0;
    end else begin
      present_first <= (state == RD_A2) && (state_nxt == PRESENT);
      if (state == RD_A1) ir <= mem_data;
      if (state == RD_A2) arg1_q <= mem_data;
      if (present_first) arg2_q <= mem_data;
      if (start) begin
        pc_q      <= start_addr;
        retired_q <= '0;
      end else if (advance) begin
        pc_q <= ADDRW'(EW'(pc_q) + off_ext);
        if (retired_q != '1) retired_q <= retired_q + CNTW'(1);
      end
    end
  end

  // arg2's byte arrives in the first PRESENT cycle; bypass it so the value
  // seen by control is the same on every PRESENT cycle.
  assign arg2    = present_first ? mem_data : arg2_q;
  assign arg1    = arg1_q;
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: byte memory model, directed scenarios
// and a randomized program walk checked against a PC/retire reference model.
module tb_instr_fetch;

  localparam int ADDRW = 16;
  localparam int CNTW  = 4;
  localparam int RMAX  = (1 << CNTW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [ADDRW-1:0] start_addr = '0;
  logic [ADDRW-1:0] mem_addr;
  logic             mem_en;
  logic [7:0]       mem_data = 8'h00;
  logic [7:0]       op_code, arg1, arg2;
  logic [15:0]      offset = '0;
  logic             op_done = 1'b0;
  logic [ADDRW-1:0] pc;
  logic             busy, halted;
  logic [CNTW-1:0]  retired;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:65535];

  instr_fetch #(.ADDRW(ADDRW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .offset(offset),
    .op_done(op_done), .pc(pc), .busy(busy), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  task automatic fill_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(1, 255));
  endtask

  // Leaves the bench at the negedge where the DUT sits in RD_OP.
  task automatic do_start(input logic [ADDRW-1:0] a);
    @(negedge clk);
    start = 1'b1; start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_present(output int cyc);
    cyc = 0;
    while (op_code == 8'h00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    total++;
    if (busy !== 1'b0 || halted !== 1'b0 || mem_en !== 1'b0 || op_code !== 8'h00 ||
        pc !== '0 || retired !== '0 || arg1 !== 8'h00 || arg2 !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: busy=%b halted=%b mem_en=%b op=%h pc=%h ret=%0d a1=%h a2=%h want all zero",
               busy, halted, mem_en, op_code, pc, retired, arg1, arg2);
    end
  endtask

  task automatic test_straight_line();
    int cyc;
    mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h00;
    do_start(16'h0000);
    wait_present(cyc);
    total++;
    if (cyc != 3 || op_code !== 8'h10 || arg1 !== 8'h05 || arg2 !== 8'h00 || pc !== 16'h0000) begin
      bad++;
      $display("FAIL straight_present: cyc=%0d op=%h a1=%h a2=%h pc=%h want 3 10 05 00 0000",
               cyc, op_code, arg1, arg2, pc);
    end
    op_done = 1'b1; offset = 16'd2;
    #1;
    total++;
    if (op_code !== 8'h00) begin
      bad++;
      $display("FAIL mask_same_cycle: op=%h want 00", op_code);
    end
    @(negedge clk);
    op_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (op_code !== 8'h00 || busy !== 1'b1) begin
        bad++;
        $display("FAIL mask_refetch: cycle %0d op=%h busy=%b want 00 1", k, op_code, busy);
      end
      @(negedge clk);
    end
    total++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 16'h0002 || retired !== CNTW'(1) ||
        op_code !== 8'h00 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL straight_halt: halted=%b busy=%b pc=%h ret=%0d op=%h en=%b want 1 0 0002 1 00 0",
               halted, busy, pc, retired, op_code, mem_en);
    end
  endtask

  task automatic test_backward_jump();
    int cyc;
    logic [15:0] seen [3];
    mem[16'h20] = 8'h42;
    do_start(16'h0020);
    wait_present(cyc);
    op_done = 1'b1; offset = 16'hFFF0;
    @(negedge clk);
    op_done = 1'b0;
    seen[0] = mem_addr;
    @(negedge clk);
    seen[1] = mem_addr;
    op_done = 1'b1; offset = 16'h0100;  // outside PRESENT: must be ignored
    @(negedge clk);
    op_done = 1'b0;
    seen[2] = mem_addr;
    total++;
    if (seen[0] !== 16'h0010 || seen[1] !== 16'h0011 || seen[2] !== 16'h0012) begin
      bad++;
      $display("FAIL back_jump_addr: got %h %h %h want 0010 0011 0012", seen[0], seen[1], seen[2]);
    end
    @(negedge clk);
    total++;
    if (pc !== 16'h0010 || retired !== CNTW'(1) || op_code !== mem[16'h10]) begin
      bad++;
      $display("FAIL back_jump_pc: pc=%h ret=%0d op=%h want 0010 1 %h", pc, retired, op_code, mem[16'h10]);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [15:0] seen [3];
    mem[16'hFFFF] = 8'h33; mem[0] = 8'h44; mem[1] = 8'h55;
    do_start(16'hFFFF);
    seen[0] = mem_addr;
    @(negedge clk);
    seen[1] = mem_addr;
    @(negedge clk);
    seen[2] = mem_addr;
    total++;
    if (seen[0] !== 16'hFFFF || seen[1] !== 16'h0000 || seen[2] !== 16'h0001) begin
      bad++;
      $display("FAIL wrap_addr: got %h %h %h want ffff 0000 0001", seen[0], seen[1], seen[2]);
    end
    wait_present(cyc);
    total++;
    if (op_code !== 8'h33 || arg1 !== 8'h44 || arg2 !== 8'h55) begin
      bad++;
      $display("FAIL wrap_bytes: op=%h a1=%h a2=%h want 33 44 55", op_code, arg1, arg2);
    end
    op_done = 1'b1; offset = 16'd3;
    @(negedge clk);
    op_done = 1'b0;
    total++;
    if (pc !== 16'h0002) begin
      bad++;
      $display("FAIL wrap_pc: pc=%h want 0002", pc);
    end
  endtask

  task automatic test_restart();
    int cyc;
    fill_mem();
    do_start(16'h0100);
    wait_present(cyc);
    op_done = 1'b1; offset = 16'd4;
    @(negedge clk);
    op_done = 1'b0;
    wait_present(cyc);
    op_done = 1'b1; offset = 16'd8; start = 1'b1; start_addr = 16'h0040;
    @(negedge clk);
    op_done = 1'b0; start = 1'b0;
    total++;
    if (pc !== 16'h0040 || retired !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_state: pc=%h ret=%0d busy=%b want 0040 0 1", pc, retired, busy);
    end
    wait_present(cyc);
    total++;
    if (cyc != 3 || op_code !== mem[16'h40] || arg1 !== mem[16'h41] || arg2 !== mem[16'h42]) begin
      bad++;
      $display("FAIL restart_fetch: cyc=%0d op=%h a1=%h a2=%h want 3 %h %h %h",
               cyc, op_code, arg1, arg2, mem[16'h40], mem[16'h41], mem[16'h42]);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_start(16'h0200);
    wait_present(cyc);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (op_code !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_present: op=%h busy=%b want 00 0", op_code, busy);
    end
    #3 rst_n = 1'b1;
    do_start(16'h0300);
    @(negedge clk);  // RD_A1
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || halted !== 1'b0 || mem_en !== 1'b0 || op_code !== 8'h00 ||
        pc !== '0 || retired !== '0 || arg1 !== 8'h00 || arg2 !== 8'h00) begin
      bad++;
      $display("FAIL reset_rd_a1: busy=%b halted=%b en=%b op=%h pc=%h ret=%0d a1=%h a2=%h want all zero",
               busy, halted, mem_en, op_code, pc, retired, arg1, arg2);
    end
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_en !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_hold: busy=%b en=%b halted=%b want 0 0 0", busy, mem_en, halted);
    end
  endtask

  // Random walk: the model tracks PC as start + sum of signed offsets mod 2^16
  // and the retire count as min(n, counter max).
  task automatic test_random_walk();
    int cyc, hold, n;
    logic [15:0] mpc, off, tgt;
    logic [7:0] e_op, e_a1, e_a2;
    fill_mem();
    n   = 20;
    mpc = 16'($urandom);
    do_start(mpc);
    for (int k = 0; k < n; k++) begin
      wait_present(cyc);
      e_op = mem[mpc]; e_a1 = mem[16'(mpc + 16'd1)]; e_a2 = mem[16'(mpc + 16'd2)];
      total++;
      if (cyc != 3 || op_code !== e_op || arg1 !== e_a1 || arg2 !== e_a2 || pc !== mpc) begin
        bad++;
        $display("FAIL rand_present[%0d]: cyc=%0d op=%h a1=%h a2=%h pc=%h want 3 %h %h %h %h",
                 k, cyc, op_code, arg1, arg2, pc, e_op, e_a1, e_a2, mpc);
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        total++;
        if (op_code !== e_op || arg1 !== e_a1 || arg2 !== e_a2) begin
          bad++;
          $display("FAIL rand_stable[%0d]: op=%h a1=%h a2=%h want %h %h %h",
                   k, op_code, arg1, arg2, e_op, e_a1, e_a2);
        end
      end
      off = 16'($urandom);
      tgt = mpc + off;
      if (k == n - 1) mem[tgt] = 8'h00;
      op_done = 1'b1; offset = off;
      @(negedge clk);
      op_done = 1'b0;
      mpc = tgt;
      total++;
      if (pc !== mpc || retired !== CNTW'((k + 1 > RMAX) ? RMAX : k + 1)) begin
        bad++;
        $display("FAIL rand_advance[%0d]: pc=%h ret=%0d want %h %0d",
                 k, pc, retired, mpc, (k + 1 > RMAX) ? RMAX : k + 1);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== mpc || retired !== CNTW'(RMAX)) begin
      bad++;
      $display("FAIL rand_halt: halted=%b busy=%b pc=%h ret=%0d want 1 0 %h %0d",
               halted, busy, pc, retired, mpc, RMAX);
    end
  endtask

  initial begin
    fill_mem();
    #12;
    test_reset();
    rst_n = 1'b1;
    test_straight_line();
    test_backward_jump();
    test_wrap();
    test_restart();
    test_reset_mid();
    test_random_walk();
    test_random_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
